// File: rtl/crc_32_req_scheduler.sv
// Round-robin scheduler sharing INST_COUNT CRC-32 engines among REQ_COUNT multi-beat requesters.
// Optional statistics outputs (beat_count_o, stall_count_o) are enabled by `define CRC_32_SCHED_STATS_EN.
module crc_32_req_scheduler #(
  parameter int          REQ_COUNT      = 16,
  parameter int          INST_COUNT     = 4,
  parameter int          PARALLEL_DEPTH = 4,
  parameter logic [31:0] CRC_SEED       = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_XOR_OUT    = 32'hFFFF_FFFF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [REQ_COUNT-1:0]               req_valid_i,
  output logic [REQ_COUNT-1:0]               req_ready_o,
  input  logic [REQ_COUNT-1:0]               req_start_i,
  input  logic [REQ_COUNT-1:0]               req_last_i,
  input  logic [REQ_COUNT*PARALLEL_DEPTH-1:0]    req_lane_valid_i,
  input  logic [REQ_COUNT*PARALLEL_DEPTH*48-1:0] req_data_i,
  output logic [REQ_COUNT-1:0]               done_valid_o,
  input  logic [REQ_COUNT-1:0]               done_ready_i,
  output logic [REQ_COUNT*32-1:0]            done_crc_o
`ifdef CRC_32_SCHED_STATS_EN
  ,
  output logic [31:0]                        beat_count_o,
  output logic [31:0]                        stall_count_o
`endif
);

  localparam int          LANE_W   = PARALLEL_DEPTH * 48;
  localparam int          PTR_W    = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int          SLOT_W   = (INST_COUNT > 1) ? $clog2(INST_COUNT) : 1;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;  // reflected IEEE 802.3 polynomial

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } req_state_e;

  req_state_e        state_q    [REQ_COUNT];
  logic [31:0]       acc_q      [REQ_COUNT];
  logic [31:0]       done_crc_q [REQ_COUNT];
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic [REQ_COUNT-1:0] eligible;
  logic [REQ_COUNT-1:0] grant;
  logic [SLOT_W-1:0]    slot_of  [REQ_COUNT];
  logic [PTR_W-1:0]     slot_req [INST_COUNT];
  logic [31:0]          eng_out  [INST_COUNT];

  // One engine pass: each valid lane in order, each lane LSB first through the reflected CRC.
  function automatic logic [31:0] crc_pass(input logic [31:0]               crc_in,
                                           input logic [PARALLEL_DEPTH-1:0] lane_valid,
                                           input logic [LANE_W-1:0]         data);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int j = 0; j < PARALLEL_DEPTH; j++) begin
      if (lane_valid[j]) begin
        for (int b = 0; b < 48; b++) begin
          fb = c[0] ^ data[j*48+b];
          c  = {1'b0, c[31:1]} ^ (fb ? CRC_POLY : 32'h0);
        end
      end
    end
    return c;
  endfunction

  always_comb begin
    for (int i = 0; i < REQ_COUNT; i++) begin
      eligible[i] = req_valid_i[i] && (state_q[i] != ST_DONE);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    int n_grant;
    int idx;
    int last_idx;
    grant    = '0;
    slot_of  = '{default: '0};
    slot_req = '{default: '0};
    n_grant  = 0;
    last_idx = int'(ptr_q);
    for (int k = 0; k < REQ_COUNT; k++) begin
      idx = (int'(ptr_q) + k) % REQ_COUNT;
      if (eligible[idx] && (n_grant < INST_COUNT)) begin
        grant[idx]         = 1'b1;
        slot_of[idx]       = SLOT_W'(n_grant);
        slot_req[n_grant]  = PTR_W'(idx);
        n_grant            = n_grant + 1;
        last_idx           = idx;
      end
    end
    // Nothing is accepted while reset is held, even though eligibility ignores it.
    if (!rst_n) begin
      grant = '0;
    end
    ptr_d = (n_grant != 0) ? PTR_W'((last_idx + 1) % REQ_COUNT) : ptr_q;
  end

  always_comb begin
    int          r;
    logic [31:0] eng_in;
    for (int k = 0; k < INST_COUNT; k++) begin
      r          = int'(slot_req[k]);
      eng_in     = req_start_i[r] ? CRC_SEED : acc_q[r];
      eng_out[k] = crc_pass(eng_in,
                            req_lane_valid_i[r*PARALLEL_DEPTH +: PARALLEL_DEPTH],
                            req_data_i[r*LANE_W +: LANE_W]);
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
  // NOTE: the accumulator and result arrays are reset because reset must discard in-flight jobs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < REQ_COUNT; i++) begin
        state_q[i]    <= ST_IDLE;
        acc_q[i]      <= CRC_SEED;
        done_crc_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (grant[i]) begin
          acc_q[i] <= eng_out[slot_of[i]];
          if (req_last_i[i]) begin
            state_q[i]    <= ST_DONE;
            done_crc_q[i] <= eng_out[slot_of[i]] ^ CRC_XOR_OUT;
          end else begin
            state_q[i] <= ST_ACTIVE;
          end
        end else if ((state_q[i] == ST_DONE) && done_ready_i[i]) begin
          state_q[i] <= ST_IDLE;
          acc_q[i]   <= CRC_SEED;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = grant;
    for (int i = 0; i < REQ_COUNT; i++) begin
      done_valid_o[i]        = (state_q[i] == ST_DONE);
      done_crc_o[i*32 +: 32] = done_crc_q[i];
    end
  end

`ifdef CRC_32_SCHED_STATS_EN
  logic [31:0] beat_q, stall_q;
  logic [31:0] n_beats;
  logic [32:0] beat_sum;
  logic        stall_any;

  always_comb begin
    n_beats = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      n_beats = n_beats + 32'(grant[i]);
    end
    beat_sum  = {1'b0, beat_q} + {1'b0, n_beats};
    stall_any = |(eligible & ~grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      beat_q <= beat_sum[32] ? 32'hFFFF_FFFF : beat_sum[31:0];
      if (stall_any && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign beat_count_o  = beat_q;
  assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_crc_32_req_scheduler.sv
// Directed self-checking bench for crc_32_req_scheduler; expected CRCs come from a byte-wise reference model.
module tb_crc_32_req_scheduler;

  localparam int REQ_COUNT      = 16;
  localparam int INST_COUNT     = 4;
  localparam int PARALLEL_DEPTH = 4;
  localparam int LANE_W         = PARALLEL_DEPTH * 48;

  logic                                  clk = 1'b0;
  logic                                  rst_n;
  logic [REQ_COUNT-1:0]                  req_valid;
  logic [REQ_COUNT-1:0]                  req_ready;
  logic [REQ_COUNT-1:0]                  req_start;
  logic [REQ_COUNT-1:0]                  req_last;
  logic [REQ_COUNT*PARALLEL_DEPTH-1:0]   req_lane_valid;
  logic [REQ_COUNT*LANE_W-1:0]           req_data;
  logic [REQ_COUNT-1:0]                  done_valid;
  logic [REQ_COUNT-1:0]                  done_ready;
  logic [REQ_COUNT*32-1:0]               done_crc;
`ifdef CRC_32_SCHED_STATS_EN
  logic [31:0]                           beat_count;
  logic [31:0]                           stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  crc_32_req_scheduler #(
    .REQ_COUNT     (REQ_COUNT),
    .INST_COUNT    (INST_COUNT),
    .PARALLEL_DEPTH(PARALLEL_DEPTH),
    .CRC_SEED      (32'hFFFF_FFFF),
    .CRC_XOR_OUT   (32'hFFFF_FFFF)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_start_i     (req_start),
    .req_last_i      (req_last),
    .req_lane_valid_i(req_lane_valid),
    .req_data_i      (req_data),
    .done_valid_o    (done_valid),
    .done_ready_i    (done_ready),
    .done_crc_o      (done_crc)
`ifdef CRC_32_SCHED_STATS_EN
    ,
    .beat_count_o    (beat_count),
    .stall_count_o   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference CRC-32: byte at a time, reflected, each 48-bit lane sent as 6 bytes low byte first.
  function automatic logic [31:0] ref_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] ref_beat(input logic [31:0] c, input logic [PARALLEL_DEPTH-1:0] lv,
                                           input logic [LANE_W-1:0] data);
    logic [31:0] r;
    r = c;
    for (int j = 0; j < PARALLEL_DEPTH; j++)
      if (lv[j]) for (int b = 0; b < 6; b++) r = ref_byte(r, data[j*48 + b*8 +: 8]);
    return r;
  endfunction

  function automatic logic [LANE_W-1:0] rand_data();
    logic [LANE_W-1:0] d;
    for (int w = 0; w < LANE_W / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid      = '0;
    req_start      = '0;
    req_last       = '0;
    req_lane_valid = '0;
    req_data       = '0;
    done_ready     = '0;
  endtask

  task automatic set_beat(input int i, input logic start, input logic last,
                          input logic [PARALLEL_DEPTH-1:0] lv, input logic [LANE_W-1:0] data);
    req_valid[i]                                     = 1'b1;
    req_start[i]                                     = start;
    req_last[i]                                      = last;
    req_lane_valid[i*PARALLEL_DEPTH +: PARALLEL_DEPTH] = lv;
    req_data[i*LANE_W +: LANE_W]                      = data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  logic [31:0]                     exp_crc;
  logic [LANE_W-1:0]               d;
  logic [PARALLEL_DEPTH-1:0]       lv;
  logic [7:0]                      ascii [9];
  logic [15:0]                     exp_ready;

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // Reference model sanity: the standard "123456789" check value.
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_crc = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) exp_crc = ref_byte(exp_crc, ascii[i]);
    check("ref_model_check", exp_crc ^ 32'hFFFF_FFFF, 32'hCBF4_3926);

    // Reset state, with every requester asking.
    req_valid = '1;
    #12;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_done_valid", 32'(done_valid), 32'h0);
    check("rst_done_crc3", done_crc[3*32 +: 32], 32'h0);
    req_valid = '0;
    #1 rst_n = 1'b1;
    tick();

    // Empty START+LAST beat on requester 3: seed ^ xor_out = 0.
    set_beat(3, 1'b1, 1'b1, '0, '0);
    #1;
    check("empty_ready", 32'(req_ready), 32'h0000_0008);
    tick();
    clear_inputs();
    #1;
    check("empty_done_valid", 32'(done_valid), 32'h0000_0008);
    check("empty_done_crc", done_crc[3*32 +: 32], 32'h0);
    done_ready[3] = 1'b1;
    tick();
    clear_inputs();
    check("empty_consumed", 32'(done_valid), 32'h0);

    // Round-robin across all 16 with PTR starting from 0.
    do_reset();
    for (int i = 0; i < REQ_COUNT; i++) set_beat(i, 1'b1, 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_ready = 16'h000F << (4 * (c % 4));
      check($sformatf("rr_grant_c%0d", c), 32'(req_ready), 32'(exp_ready));
      tick();
    end
    clear_inputs();

    // Requester 5: three-beat job, middle beat has no valid lanes.
    exp_crc = 32'hFFFF_FFFF;
    for (int bt = 0; bt < 3; bt++) begin
      lv = (bt == 0) ? 4'b1011 : (bt == 1) ? 4'b0000 : 4'b1111;
      d  = rand_data();
      set_beat(5, bt == 0, bt == 2, lv, d);
      exp_crc = ref_beat(exp_crc, lv, d);
      #1;
      check($sformatf("job5_ready_b%0d", bt), 32'(req_ready), 32'h0000_0020);
      if (bt < 2) check($sformatf("job5_busy_b%0d", bt), 32'(done_valid), 32'h0);
      tick();
    end
    exp_crc = exp_crc ^ 32'hFFFF_FFFF;
    clear_inputs();
    #1;
    check("job5_done_valid", 32'(done_valid), 32'h0000_0020);
    check("job5_crc", done_crc[5*32 +: 32], exp_crc);

    // Hold result 5 unconsumed while 5 and 6 both ask; only 6 gets through.
    for (int c = 0; c < 10; c++) begin
      set_beat(5, 1'b0, 1'b1, 4'b1111, '1);
      set_beat(6, 1'b1, 1'b0, '0, '0);
      #1;
      check($sformatf("stall5_ready_c%0d", c), 32'(req_ready), 32'h0000_0040);
      tick();
    end
    check("stall5_crc_stable", done_crc[5*32 +: 32], exp_crc);
    done_ready[5] = 1'b1;
    #1;
    check("consume_cycle_ready", 32'(req_ready), 32'h0000_0040);
    tick();
    done_ready[5] = 1'b0;
    lv = 4'b0110;
    d  = rand_data();
    set_beat(5, 1'b0, 1'b1, lv, d);
    exp_crc = ref_beat(32'hFFFF_FFFF, lv, d) ^ 32'hFFFF_FFFF;
    #1;
    check("after_consume_ready", 32'(req_ready), 32'h0000_0060);
    tick();
    clear_inputs();
    check("reseeded_crc5", done_crc[5*32 +: 32], exp_crc);

    // Requester 2 mid-job, result 5 still pending, then asynchronous reset.
    set_beat(2, 1'b1, 1'b0, 4'b0101, rand_data());
    #1;
    check("job2_ready", 32'(req_ready), 32'h0000_0004);
    tick();
    clear_inputs();
    check("pre_rst_done_valid", 32'(done_valid), 32'h0000_0020);
    #1 rst_n = 1'b0;
    req_valid[2] = 1'b1;
    #1;
    check("midrst_done_valid", 32'(done_valid), 32'h0);
    check("midrst_done_crc5", done_crc[5*32 +: 32], 32'h0);
    check("midrst_ready", 32'(req_ready), 32'h0);
    #1 rst_n = 1'b1;
    clear_inputs();
    tick();

    // Post-reset job on 2 without START must still begin from the seed.
    exp_crc = 32'hFFFF_FFFF;
    for (int bt = 0; bt < 2; bt++) begin
      lv = (bt == 0) ? 4'b1111 : 4'b0011;
      d  = rand_data();
      set_beat(2, 1'b0, bt == 1, lv, d);
      exp_crc = ref_beat(exp_crc, lv, d);
      tick();
    end
    clear_inputs();
    check("job2_done_valid", 32'(done_valid), 32'h0000_0004);
    check("job2_crc", done_crc[2*32 +: 32], exp_crc ^ 32'hFFFF_FFFF);

`ifdef CRC_32_SCHED_STATS_EN
    // 16 single-beat offers drain over 4 cycles; the last cycle has no stall.
    do_reset();
    check("stats_rst_beats", beat_count, 32'd0);
    for (int i = 0; i < REQ_COUNT; i++) set_beat(i, 1'b1, 1'b0, '0, '0);
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_ready = req_ready;
      tick();
      req_valid = req_valid & ~exp_ready;
    end
    clear_inputs();
    tick();
    check("stats_beats", beat_count, 32'd16);
    check("stats_stalls", stall_count, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
